// File: rtl/mips_pkg.sv
// Shared constants and types for the writeback path into the register file.
package mips_pkg;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      WB_IDLE,
      WB_WRITE,
      WB_BLOCKED
   } wb_state_t;

   localparam int WB_ALU  = 0;
   localparam int WB_LOAD = 1;
   localparam int WB_MDU  = 2;

endpackage

// File: rtl/regfile_wb_arbiter_rr_pick.sv
// Combinational round-robin picker: lowest requester at or above ptr wins,
// otherwise the lowest requester overall (wrap-around).
module rr_pick #(
   parameter int N     = 3,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   logic [N-1:0] mask_hi;
   logic [N-1:0] masked;
   logic [N-1:0] sel;

   always_comb begin
      mask_hi = '0;
      for (int i = 0; i < N; i++) begin
         mask_hi[i] = (i >= int'(ptr));
      end
      masked = req & mask_hi;
      sel    = (|masked) ? masked : req;
      any    = |req;
      gnt    = '0;
      idx    = '0;
      // walk downward so the lowest set bit is the last one written
      for (int i = N - 1; i >= 0; i--) begin
         if (sel[i]) begin
            gnt    = '0;
            gnt[i] = 1'b1;
            idx    = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port among writeback
// sources, with one registered output stage that can be held by rf_block.
//
//   state      | meaning
//   WB_IDLE    | output stage empty
//   WB_WRITE   | rf_we=1 this cycle, write commits at the next edge
//   WB_BLOCKED | write held while the core owns the port, rf_we=0
module regfile_wb_arbiter
   import mips_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic                      rf_block,
   output logic                      rf_we,
   output logic [ADDR_W-1:0]         rf_waddr,
   output logic [DATA_W-1:0]         rf_wdata,
   output logic [IDX_W-1:0]          grant_id,
   output logic                      busy
);

   wb_state_t          state_q, state_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [ADDR_W-1:0]  waddr_q, waddr_d;
   logic [DATA_W-1:0]  wdata_q, wdata_d;
   logic [IDX_W-1:0]   grant_id_q, grant_id_d;

   logic [NUM_REQ-1:0] pick_gnt;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_any;
   logic               out_free;
   logic               accept;
   logic [ADDR_W-1:0]  win_addr;
   logic [DATA_W-1:0]  win_data;
   logic               win_zero;

   rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
      .req (req_valid),
      .ptr (rr_ptr_q),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   assign out_free = (state_q == WB_IDLE) || (state_q == WB_WRITE);
   // rst_n gating keeps ready low while reset is held, even with IDLE state
   assign accept   = out_free && pick_any && rst_n;
   assign win_addr = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
   assign win_data = req_data[int'(pick_idx)*DATA_W +: DATA_W];
   assign win_zero = (win_addr == ADDR_W'(REG_ZERO));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= WB_IDLE;
         rr_ptr_q   <= '0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         grant_id_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         grant_id_q <= grant_id_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      grant_id_d = grant_id_q;
      if (accept) begin
         rr_ptr_d = (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + IDX_W'(1);
      end
      case (state_q)
         WB_IDLE, WB_WRITE: begin
            // a $zero write is consumed but never reaches the output stage
            if (accept && !win_zero) begin
               state_d    = rf_block ? WB_BLOCKED : WB_WRITE;
               waddr_d    = win_addr;
               wdata_d    = win_data;
               grant_id_d = pick_idx;
            end else begin
               state_d = WB_IDLE;
            end
         end
         WB_BLOCKED: begin
            if (!rf_block) state_d = WB_WRITE;
         end
         default: state_d = WB_IDLE;
      endcase
   end

   always_comb begin
      req_ready = accept ? pick_gnt : '0;
      rf_we     = (state_q == WB_WRITE);
      busy      = (state_q != WB_IDLE);
      rf_waddr  = waddr_q;
      rf_wdata  = wdata_q;
      grant_id  = grant_id_q;
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with hand-computed expectations.
module tb_regfile_wb_arbiter;

   localparam int NUM_REQ = 3;
   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 5;

   logic                      clk = 1'b0;
   logic                      rst_n;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic                      rf_block;
   logic                      rf_we;
   logic [ADDR_W-1:0]         rf_waddr;
   logic [DATA_W-1:0]         rf_wdata;
   logic [1:0]                grant_id;
   logic                      busy;

   int n_checks = 0;
   int n_fail   = 0;

   regfile_wb_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .rf_block  (rf_block),
      .rf_we     (rf_we),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      req_addr[i*ADDR_W +: ADDR_W] = a;
      req_data[i*DATA_W +: DATA_W] = d;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      rf_block  = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic chk_out(input string tag, input logic we, input logic [4:0] a,
                          input logic [1:0] g, input logic b);
      chk({tag, "_we"}, 32'(rf_we), 32'(we));
      chk({tag, "_waddr"}, 32'(rf_waddr), 32'(a));
      chk({tag, "_gid"}, 32'(grant_id), 32'(g));
      chk({tag, "_busy"}, 32'(busy), 32'(b));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      req_valid = 3'b111;
      req_addr  = '0;
      req_data  = '0;
      rf_block  = 1'b0;
      set_req(0, 5'd3, 32'h11);
      #2;
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk_out("rst", 1'b0, 5'd0, 2'd0, 1'b0);
      chk("rst_wdata", rf_wdata, 32'h0);
      tick();
      do_reset();

      // T2 single write
      set_req(0, 5'd5, 32'hDEADBEEF);
      req_valid = 3'b001;
      #1 chk("t2_ready", 32'(req_ready), 32'h1);
      tick();
      req_valid = '0;
      chk_out("t2", 1'b1, 5'd5, 2'd0, 1'b1);
      chk("t2_wdata", rf_wdata, 32'hDEADBEEF);
      tick();
      chk_out("t2_drain", 1'b0, 5'd5, 2'd0, 1'b0);

      // T3 round robin, back-to-back
      do_reset();
      for (int i = 0; i < 3; i++) set_req(i, 5'(i + 1), 32'h100 + 32'(i));
      req_valid = 3'b111;
      for (int k = 0; k < 6; k++) begin
         #1 chk("t3_ready", 32'(req_ready), 32'(1 << (k % 3)));
         tick();
         if (k == 5) req_valid = '0;
         chk_out("t3", 1'b1, 5'((k % 3) + 1), 2'(k % 3), 1'b1);
         chk("t3_wdata", rf_wdata, 32'h100 + 32'(k % 3));
      end
      tick();
      chk("t3_end_we", 32'(rf_we), 32'h0);

      // T4 block for three cycles
      do_reset();
      set_req(0, 5'd9, 32'h99);
      set_req(1, 5'd1, 32'h1);
      set_req(2, 5'd2, 32'h2);
      req_valid = 3'b001;
      rf_block  = 1'b1;
      #1 chk("t4_ready", 32'(req_ready), 32'h1);
      tick();
      req_valid = 3'b110;
      for (int k = 0; k < 3; k++) begin
         #1 chk("t4_hold_ready", 32'(req_ready), 32'h0);
         chk_out("t4_hold", 1'b0, 5'd9, 2'd0, 1'b1);
         if (k < 2) tick();
      end
      rf_block  = 1'b0;
      req_valid = '0;
      tick();
      chk_out("t4_rel", 1'b1, 5'd9, 2'd0, 1'b1);
      chk("t4_wdata", rf_wdata, 32'h99);
      tick();
      chk("t4_end_we", 32'(rf_we), 32'h0);

      // rf_block rising during WRITE only holds the following write
      do_reset();
      set_req(0, 5'd5, 32'h55);
      set_req(1, 5'd6, 32'h66);
      req_valid = 3'b001;
      tick();
      req_valid = 3'b010;
      rf_block  = 1'b1;
      #1 chk("wb_ready", 32'(req_ready), 32'h2);
      chk_out("wb_cur", 1'b1, 5'd5, 2'd0, 1'b1);
      tick();
      req_valid = '0;
      chk_out("wb_next", 1'b0, 5'd6, 2'd1, 1'b1);
      rf_block = 1'b0;
      tick();
      chk_out("wb_rel", 1'b1, 5'd6, 2'd1, 1'b1);

      // T5 $zero request is consumed and dropped
      do_reset();
      set_req(1, 5'd0, 32'h1234);
      req_valid = 3'b010;
      #1 chk("t5_zready", 32'(req_ready), 32'h2);
      tick();
      chk_out("t5_zero", 1'b0, 5'd0, 2'd0, 1'b0);
      set_req(1, 5'd3, 32'h33);
      set_req(2, 5'd4, 32'h44);
      req_valid = 3'b110;
      #1 chk("t5_ready2", 32'(req_ready), 32'h4);
      tick();
      req_valid = 3'b010;
      chk_out("t5_w4", 1'b1, 5'd4, 2'd2, 1'b1);
      chk("t5_wdata", rf_wdata, 32'h44);
      #1 chk("t5_ready1", 32'(req_ready), 32'h2);
      tick();
      req_valid = '0;
      chk_out("t5_w3", 1'b1, 5'd3, 2'd1, 1'b1);

      // T6 wrap with gaps from rr_ptr=2
      do_reset();
      set_req(1, 5'd1, 32'h1);
      req_valid = 3'b010;
      tick();
      set_req(0, 5'd10, 32'hA);
      set_req(1, 5'd11, 32'hB);
      req_valid = 3'b011;
      #1 chk("t6_ready0", 32'(req_ready), 32'h1);
      tick();
      req_valid = 3'b010;
      chk_out("t6_g0", 1'b1, 5'd10, 2'd0, 1'b1);
      #1 chk("t6_ready1", 32'(req_ready), 32'h2);
      tick();
      req_valid = '0;
      chk_out("t6_g1", 1'b1, 5'd11, 2'd1, 1'b1);

      // T1 reset asserted mid-BLOCKED discards the held write
      do_reset();
      set_req(0, 5'd7, 32'h77);
      req_valid = 3'b001;
      rf_block  = 1'b1;
      tick();
      req_valid = '0;
      chk_out("t1_blk", 1'b0, 5'd7, 2'd0, 1'b1);
      rst_n = 1'b0;
      #1 chk_out("t1_rst", 1'b0, 5'd0, 2'd0, 1'b0);
      tick();
      rst_n    = 1'b1;
      rf_block = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("t1_no_we", 32'(rf_we), 32'h0);
         chk("t1_waddr", 32'(rf_waddr), 32'h0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
